// File: rtl/vfs_pkg.sv
// Shared types and helpers for the triple-buffer video frame scheduler.
package vfs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VSYNC,
        START,
        RUN
    } vfs_state_t;

    typedef logic [1:0] buf_idx_t;

    localparam int unsigned NUM_BUFS = 3;

    // With three buffers indexed 0..2 the indices sum to 3, so the free one is 3-a-b.
    function automatic buf_idx_t third_idx(buf_idx_t a, buf_idx_t b);
        return 2'd3 - a - b;
    endfunction

endpackage

// File: rtl/video_frame_scheduler_if.sv
// Producer write-path and DMA-master control signals of the frame scheduler.
interface video_frame_scheduler_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              wr_frame_done;
    logic [ADDR_W-1:0] wr_base_addr;
    logic              dma_busy;
    logic              dma_done;
    logic              dma_start;
    logic [ADDR_W-1:0] dma_start_addr;

    modport master (
        input  wr_frame_done,
        input  dma_busy,
        input  dma_done,
        output wr_base_addr,
        output dma_start,
        output dma_start_addr
    );

    modport slave (
        output wr_frame_done,
        output dma_busy,
        output dma_done,
        input  wr_base_addr,
        input  dma_start,
        input  dma_start_addr
    );
endinterface

// File: rtl/vfs_buf_tracker.sv
// Tracks displayed / written / ready buffer indices; the drop strobe exists only
// when VFS_STATS_EN is defined.
module vfs_buf_tracker
    import vfs_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     wr_frame_done,
    input  logic     take,
    output buf_idx_t disp_idx_next,
    output buf_idx_t wr_idx_next
`ifdef VFS_STATS_EN
    ,
    output logic     drop
`endif
);

    buf_idx_t disp_idx, wr_idx, ready_idx;
    logic     ready_valid;

    buf_idx_t disp_n, wr_n, ready_n;
    logic     ready_valid_n;
    logic     drop_n;

    always_comb begin
        disp_n        = disp_idx;
        wr_n          = wr_idx;
        ready_n       = ready_idx;
        ready_valid_n = ready_valid;
        drop_n        = 1'b0;
        if (wr_frame_done && take) begin
            // Completion applies first, so the consumer takes the frame just written.
            disp_n        = wr_idx;
            wr_n          = third_idx(disp_idx, wr_idx);
            ready_valid_n = 1'b0;
            drop_n        = ready_valid;
        end else if (wr_frame_done) begin
            ready_n       = wr_idx;
            ready_valid_n = 1'b1;
            wr_n          = third_idx(disp_idx, wr_idx);
            drop_n        = ready_valid;
        end else if (take && ready_valid) begin
            disp_n        = ready_idx;
            ready_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_idx    <= 2'd0;
            wr_idx      <= 2'd1;
            ready_idx   <= 2'd2;
            ready_valid <= 1'b0;
        end else begin
            disp_idx    <= disp_n;
            wr_idx      <= wr_n;
            ready_idx   <= ready_n;
            ready_valid <= ready_valid_n;
        end
    end

    assign disp_idx_next = disp_n;
    assign wr_idx_next   = wr_n;
`ifdef VFS_STATS_EN
    assign drop          = drop_n;
`endif

endmodule

// File: rtl/video_frame_scheduler.sv
// Triple-buffer controller sequencing the video read DMA on each vsync.
// Define VFS_STATS_EN to add the frames_shown / frames_dropped counters.
module video_frame_scheduler
    import vfs_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(32'd3686400)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     vsync_edge,
    input  logic                     clear_status,
    video_frame_scheduler_if.master  bus,
    output logic [ADDR_W-1:0]        disp_base_addr,
    output logic                     late_vsync
`ifdef VFS_STATS_EN
    ,
    output logic [15:0]              frames_shown,
    output logic [15:0]              frames_dropped
`endif
);

    function automatic logic [ADDR_W-1:0] buf_addr(buf_idx_t i);
        return BASE_ADDR + FRAME_BYTES * ADDR_W'(i);
    endfunction

    vfs_state_t state, state_n;
    logic       take;
    logic       late_set;
    logic       dma_start;

    buf_idx_t          disp_idx_next, wr_idx_next;
    logic [ADDR_W-1:0] wr_base_addr_q;
    logic [ADDR_W-1:0] dma_start_addr_q;

`ifdef VFS_STATS_EN
    logic drop;
`endif

    vfs_buf_tracker u_buf_tracker (
        .clk           (clk),
        .reset         (reset),
        .wr_frame_done (bus.wr_frame_done),
        .take          (take),
        .disp_idx_next (disp_idx_next),
        .wr_idx_next   (wr_idx_next)
`ifdef VFS_STATS_EN
        ,
        .drop          (drop)
`endif
    );

    always_comb begin
        state_n   = state;
        take      = 1'b0;
        late_set  = 1'b0;
        dma_start = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_n = WAIT_VSYNC;
            end
            WAIT_VSYNC: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (vsync_edge) begin
                    if (bus.dma_busy) begin
                        late_set = 1'b1;
                    end else begin
                        take    = 1'b1;
                        state_n = START;
                    end
                end
            end
            START: begin
                dma_start = 1'b1;
                state_n   = RUN;
            end
            RUN: begin
                // A vsync during a running frame is flagged, never queued.
                if (vsync_edge) late_set = 1'b1;
                if (bus.dma_done) state_n = enable ? WAIT_VSYNC : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_base_addr_q   <= buf_addr(2'd1);
            disp_base_addr   <= buf_addr(2'd0);
            dma_start_addr_q <= buf_addr(2'd0);
        end else begin
            wr_base_addr_q <= buf_addr(wr_idx_next);
            disp_base_addr <= buf_addr(disp_idx_next);
            if (take) dma_start_addr_q <= buf_addr(disp_idx_next);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            late_vsync <= 1'b0;
        end else if (clear_status) begin
            late_vsync <= 1'b0;
        end else if (late_set) begin
            late_vsync <= 1'b1;
        end
    end

`ifdef VFS_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames_shown   <= '0;
            frames_dropped <= '0;
        end else if (clear_status) begin
            frames_shown   <= '0;
            frames_dropped <= '0;
        end else begin
            if (dma_start && frames_shown != '1) frames_shown <= frames_shown + 16'd1;
            if (drop && frames_dropped != '1) frames_dropped <= frames_dropped + 16'd1;
        end
    end
`endif

    assign bus.dma_start      = dma_start;
    assign bus.dma_start_addr = dma_start_addr_q;
    assign bus.wr_base_addr   = wr_base_addr_q;

endmodule

// File: tb/tb_video_frame_scheduler.sv
// Self-checking bench for video_frame_scheduler: directed scenarios plus random traffic vs a reference model.
module tb_video_frame_scheduler;

    localparam int unsigned ADDR_W      = 32;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
    localparam logic [31:0] FRAME_BYTES = 32'd3686400;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        vsync_edge;
    logic        clear_status;
    logic [31:0] disp_base_addr;
    logic        late_vsync;
`ifdef VFS_STATS_EN
    logic [15:0] frames_shown;
    logic [15:0] frames_dropped;
`endif

    video_frame_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    video_frame_scheduler #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE_ADDR),
        .FRAME_BYTES (FRAME_BYTES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .vsync_edge     (vsync_edge),
        .clear_status   (clear_status),
        .bus            (bus),
        .disp_base_addr (disp_base_addr),
        .late_vsync     (late_vsync)
`ifdef VFS_STATS_EN
        ,
        .frames_shown   (frames_shown),
        .frames_dropped (frames_dropped)
`endif
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: phase 0=off, 1=armed waiting for vsync, 2=start pulse, 3=frame running.
    int          m_phase;
    int          m_disp, m_wr, m_ready;
    bit          m_ready_valid;
    bit          m_late;
    logic [31:0] m_start_addr;
    int unsigned m_shown, m_dropped;

    function automatic logic [31:0] buf_addr(int i);
        logic [63:0] a;
        a = 64'(BASE_ADDR) + 64'(FRAME_BYTES) * 64'(i);
        return a[31:0];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase       = 0;
        m_disp        = 0;
        m_wr          = 1;
        m_ready       = 2;
        m_ready_valid = 0;
        m_late        = 0;
        m_start_addr  = buf_addr(0);
        m_shown       = 0;
        m_dropped     = 0;
    endtask

    task automatic model_clock();
        bit take, late_set, drop, started;
        int old_disp, old_wr;
        take     = (m_phase == 1) && enable && vsync_edge && !bus.dma_busy;
        late_set = ((m_phase == 1) && enable && vsync_edge && bus.dma_busy) ||
                   ((m_phase == 3) && vsync_edge);
        started  = (m_phase == 2);
        drop     = 0;
        old_disp = m_disp;
        old_wr   = m_wr;
        if (bus.wr_frame_done) begin
            drop = m_ready_valid;
            m_wr = 3 - old_disp - old_wr;
            if (take) begin
                m_disp        = old_wr;
                m_ready_valid = 0;
            end else begin
                m_ready       = old_wr;
                m_ready_valid = 1;
            end
        end else if (take && m_ready_valid) begin
            m_disp        = m_ready;
            m_ready_valid = 0;
        end
        if (take) m_start_addr = buf_addr(m_disp);
        if (clear_status) begin
            m_late    = 0;
            m_shown   = 0;
            m_dropped = 0;
        end else begin
            if (late_set) m_late = 1;
            if (started && m_shown < 65535) m_shown++;
            if (drop && m_dropped < 65535) m_dropped++;
        end
        case (m_phase)
            0: if (enable) m_phase = 1;
            1: if (!enable) m_phase = 0; else if (take) m_phase = 2;
            2: m_phase = 3;
            default: if (bus.dma_done) m_phase = enable ? 1 : 0;
        endcase
    endtask

    task automatic compare_all();
        check_val("dma_start", 32'(bus.dma_start), 32'(m_phase == 2));
        check_val("dma_start_addr", bus.dma_start_addr, m_start_addr);
        check_val("wr_base_addr", bus.wr_base_addr, buf_addr(m_wr));
        check_val("disp_base_addr", disp_base_addr, buf_addr(m_disp));
        check_val("late_vsync", 32'(late_vsync), 32'(m_late));
        check_val("wr_ne_disp", 32'(bus.wr_base_addr == disp_base_addr), 32'd0);
`ifdef VFS_STATS_EN
        check_val("frames_shown", 32'(frames_shown), m_shown);
        check_val("frames_dropped", 32'(frames_dropped), m_dropped);
`endif
    endtask

    task automatic cycle(input bit en, input bit vs, input bit wfd, input bit busy,
                         input bit done, input bit clr);
        enable            = en;
        vsync_edge        = vs;
        bus.wr_frame_done = wfd;
        bus.dma_busy      = busy;
        bus.dma_done      = done;
        clear_status      = clr;
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    // Reset is asserted between clock edges to exercise its asynchronous path.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    task automatic fresh_armed();
        do_reset();
        cycle(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset             = 1'b1;
        enable            = 1'b0;
        vsync_edge        = 1'b0;
        clear_status      = 1'b0;
        bus.wr_frame_done = 1'b0;
        bus.dma_busy      = 1'b0;
        bus.dma_done      = 1'b0;
        model_reset();
        #1;
        check_val("rst_wr_base", bus.wr_base_addr, 32'h0038_4000);
        check_val("rst_start_addr", bus.dma_start_addr, 32'h0000_0000);
        compare_all();

        // No producer frames: buffer 0 is shown repeatedly.
        fresh_armed();
        cycle(1, 1, 0, 0, 0, 0);
        check_val("t1_start", 32'(bus.dma_start), 32'd1);
        check_val("t1_addr", bus.dma_start_addr, 32'h0000_0000);
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 1, 0, 0, 0, 0);
        check_val("t1_repeat_addr", bus.dma_start_addr, 32'h0000_0000);

        // One finished frame is picked up on the next vsync.
        fresh_armed();
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        check_val("t2_start_addr", bus.dma_start_addr, 32'h0038_4000);
        check_val("t2_wr_base", bus.wr_base_addr, 32'h0070_8000);
        check_val("t2_disp_base", disp_base_addr, 32'h0038_4000);

        // Two finished frames: the newer wins.
        fresh_armed();
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        check_val("t3_start_addr", bus.dma_start_addr, 32'h0070_8000);
`ifdef VFS_STATS_EN
        check_val("t3_dropped", 32'(frames_dropped), 32'd1);
`endif

        // Completion and vsync together, then a late vsync during RUN.
        fresh_armed();
        cycle(1, 1, 1, 0, 0, 0);
        check_val("t4_start_addr", bus.dma_start_addr, 32'h0038_4000);
        check_val("t4_wr_ne_start", 32'(bus.wr_base_addr == bus.dma_start_addr), 32'd0);
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 1, 0, 1, 0, 0);
        check_val("t5_late", 32'(late_vsync), 32'd1);
        cycle(1, 0, 0, 1, 0, 0);
        check_val("t5_no_restart", 32'(bus.dma_start), 32'd0);
        cycle(1, 0, 0, 1, 0, 1);
        check_val("t5_cleared", 32'(late_vsync), 32'd0);

        // Disable mid-frame, then reset mid-frame.
        fresh_armed();
        cycle(1, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check_val("t6_idle_no_start", 32'(bus.dma_start), 32'd0);
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        do_reset();
        check_val("t6_rst_disp", disp_base_addr, 32'h0000_0000);
        check_val("t6_rst_start", 32'(bus.dma_start), 32'd0);
        cycle(1, 0, 0, 0, 1, 0);

        // Random traffic including stale dma_done, busy vsyncs and resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
